var_delayer: RTL and testbench



---
 rtl/var_delayer_if.sv | 37 +++
 rtl/var_delayer.sv | 115 +++++++++++
 tb/tb_var_delayer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/var_delayer_if.sv
// Handshake/data bundle for var_delayer.
// master: sample source and delay programmer; slave: the delay line.
// Optional fill_level output is present only when VAR_DELAYER_FILL_STATUS_EN is defined.
interface var_delayer_if #(
    parameter int WIDTH     = 1,
    parameter int CHANNELS  = 1,
    parameter int MAX_DELAY = 16,
    parameter int DW        = $clog2(MAX_DELAY + 1)
);
    logic                      en;
    logic [CHANNELS*WIDTH-1:0] in;
    logic [DW-1:0]             delay_in;
    logic                      delay_load;
    logic [CHANNELS*WIDTH-1:0] out;
    logic                      out_valid;
    logic [DW-1:0]             delay_cur;
    logic                      delay_err;
`ifdef VAR_DELAYER_FILL_STATUS_EN
    logic [DW-1:0]             fill_level;
`endif

    modport master (
        output en, in, delay_in, delay_load,
        input  out, out_valid, delay_cur, delay_err
`ifdef VAR_DELAYER_FILL_STATUS_EN
        , input fill_level
`endif
    );

    modport slave (
        input  en, in, delay_in, delay_load,
        output out, out_valid, delay_cur, delay_err
`ifdef VAR_DELAYER_FILL_STATUS_EN
        , output fill_level
`endif
    );
endinterface

// File: rtl/var_delayer.sv
// Runtime-programmable multi-channel delay line.
// Circular buffer of MAX_DELAY entries plus a registered output stage.
// All lanes share one write pointer, one fill counter and one delay.
// Optional: define VAR_DELAYER_FILL_STATUS_EN to expose the fill counter
// as bus.fill_level.
module var_delayer #(
    parameter int WIDTH         = 1,
    parameter int CHANNELS      = 1,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 1,
    parameter int DW            = $clog2(MAX_DELAY + 1)
) (
    input  logic            clk,
    input  logic            rst,
    var_delayer_if.slave    bus
);
    localparam int PW = $clog2(MAX_DELAY);
    localparam int SW = DW + 1;
    localparam int BW = CHANNELS * WIDTH;

    logic [BW-1:0] mem [MAX_DELAY];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_next;
    logic [PW-1:0] rd_ptr;
    logic [SW-1:0] rd_sum;
    logic [SW-1:0] rd_wrap;
    logic [DW-1:0] fill;
    logic [DW-1:0] cur;
    logic [DW-1:0] clamp_d;
    logic          clamp_hit;
    logic [BW-1:0] out_q;
    logic          valid_q;
    logic          err_q;

    // Clamp the requested delay into 1..MAX_DELAY and flag any adjustment.
    always_comb begin
        clamp_d   = bus.delay_in;
        clamp_hit = 1'b0;
        if (bus.delay_in == '0) begin
            clamp_d   = DW'(1);
            clamp_hit = 1'b1;
        end else if (bus.delay_in > DW'(MAX_DELAY)) begin
            clamp_d   = DW'(MAX_DELAY);
            clamp_hit = 1'b1;
        end
    end

    // Pointer arithmetic: read slot lags the write slot by (D-1), modulo MAX_DELAY.
    // The sum is biased by MAX_DELAY so it never goes negative; one fold suffices.
    always_comb begin
        wr_next = (wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr + PW'(1);
        rd_sum  = SW'(wr_ptr) + SW'(MAX_DELAY + 1) - SW'(cur);
        rd_wrap = (rd_sum >= SW'(MAX_DELAY)) ? rd_sum - SW'(MAX_DELAY) : rd_sum;
        rd_ptr  = PW'(rd_wrap);
    end

    // Sample storage; not reset, every enabled cycle writes the current slot.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            mem[wr_ptr] <= bus.in;
        end
    end

    // Control path: delay register, fill counter, output stage and clamp flag.
    // out is forced to zero whenever the line is not yet filled for the current
    // delay, so stale samples from an earlier delay can never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            fill    <= '0;
            cur     <= DW'(DEFAULT_DELAY);
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= bus.delay_load & clamp_hit;
            if (bus.delay_load) begin
                cur <= clamp_d;
                if (bus.en) begin
                    // The load-cycle sample is the first one under the new delay.
                    wr_ptr  <= wr_next;
                    fill    <= DW'(1);
                    valid_q <= (clamp_d == DW'(1));
                    out_q   <= (clamp_d == DW'(1)) ? bus.in : '0;
                end else begin
                    fill    <= '0;
                    valid_q <= 1'b0;
                    out_q   <= '0;
                end
            end else if (bus.en) begin
                wr_ptr <= wr_next;
                if (fill < cur) begin
                    fill <= fill + DW'(1);
                end
                if (fill >= cur - DW'(1)) begin
                    valid_q <= 1'b1;
                    out_q   <= (cur == DW'(1)) ? bus.in : mem[rd_ptr];
                end else begin
                    valid_q <= 1'b0;
                    out_q   <= '0;
                end
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.delay_cur = cur;
    assign bus.delay_err = err_q;
`ifdef VAR_DELAYER_FILL_STATUS_EN
    assign bus.fill_level = fill;
`endif

endmodule

// File: tb/tb_var_delayer.sv
// Bench for var_delayer: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_var_delayer;
    localparam int WIDTH     = 8;
    localparam int CHANNELS  = 2;
    localparam int MAX_DELAY = 16;
    localparam int DEF_D     = 3;
    localparam int DW        = $clog2(MAX_DELAY + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    var_delayer_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY)) bus ();

    var_delayer #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(DEF_D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of samples accepted since the last load/reset.
    int          m_d;
    logic [15:0] m_q[$];
    int          m_cnt;
    logic [15:0] m_out;
    logic        m_valid;
    logic        m_err;

    typedef struct {
        logic        en;
        logic [15:0] din;
        logic        load;
        logic [4:0]  dly;
        logic [15:0] exp_out;
        logic        exp_valid;
        logic [4:0]  exp_cur;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_d = DEF_D;
        m_q.delete();
        m_cnt = 0;
        m_out = '0;
        m_valid = 1'b0;
        m_err = 1'b0;
    endfunction

    function automatic void model_edge(input logic e, input logic [15:0] d,
                                       input logic ld, input logic [4:0] dl);
        int v;
        v = int'(dl);
        m_err = ld && (v == 0 || v > MAX_DELAY);
        if (ld) begin
            m_d = (v == 0) ? 1 : ((v > MAX_DELAY) ? MAX_DELAY : v);
            m_q.delete();
            m_cnt = 0;
            m_out = '0;
            m_valid = 1'b0;
        end
        if (e) begin
            m_q.push_back(d);
            if (m_q.size() > MAX_DELAY) void'(m_q.pop_front());
            m_cnt++;
            if (m_cnt >= m_d) begin
                m_valid = 1'b1;
                m_out = m_q[m_q.size() - m_d];
            end else begin
                m_valid = 1'b0;
                m_out = '0;
            end
        end
    endfunction

    // Apply one cycle of inputs, advance the model on the edge, return #1 after it.
    task automatic step(input logic e, input logic [15:0] d, input logic ld, input logic [4:0] dl);
        bus.en = e;
        bus.in = d;
        bus.delay_load = ld;
        bus.delay_in = dl;
        @(posedge clk);
        model_edge(e, d, ld, dl);
        #1;
        bus.en = 1'b0;
        bus.delay_load = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out"},       32'(bus.out),       32'(m_out));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
        check({tag, ".delay_cur"}, 32'(bus.delay_cur), 32'(m_d));
        check({tag, ".delay_err"}, 32'(bus.delay_err), 32'(m_err));
    endtask

    initial begin
        logic [15:0] s0;
        logic [15:0] first;

        bus.en = 1'b0;
        bus.in = '0;
        bus.delay_in = '0;
        bus.delay_load = 1'b0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst.out",       32'(bus.out),       32'h0);
        check("rst.out_valid", 32'(bus.out_valid), 32'h0);
        check("rst.delay_cur", 32'(bus.delay_cur), 32'(DEF_D));
        check("rst.delay_err", 32'(bus.delay_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors: en, in, load, delay_in | out, out_valid, delay_cur, delay_err
        tbl.push_back('{1'b1, 16'h0101, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd3,  1'b0});
        tbl.push_back('{1'b1, 16'h0202, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd3,  1'b0});
        tbl.push_back('{1'b1, 16'h0303, 1'b0, 5'd0,  16'h0101, 1'b1, 5'd3,  1'b0});
        tbl.push_back('{1'b1, 16'h0404, 1'b0, 5'd0,  16'h0202, 1'b1, 5'd3,  1'b0});
        tbl.push_back('{1'b1, 16'h0505, 1'b0, 5'd0,  16'h0303, 1'b1, 5'd3,  1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 5'd4,  16'h0000, 1'b0, 5'd4,  1'b0});
        tbl.push_back('{1'b1, 16'h00AA, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd4,  1'b0});
        tbl.push_back('{1'b0, 16'hEEEE, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd4,  1'b0});
        tbl.push_back('{1'b1, 16'h00BB, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd4,  1'b0});
        tbl.push_back('{1'b1, 16'h00CC, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd4,  1'b0});
        tbl.push_back('{1'b0, 16'hEEEE, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd4,  1'b0});
        tbl.push_back('{1'b1, 16'h00DD, 1'b0, 5'd0,  16'h00AA, 1'b1, 5'd4,  1'b0});
        tbl.push_back('{1'b0, 16'hEEEE, 1'b0, 5'd0,  16'h00AA, 1'b1, 5'd4,  1'b0});
        tbl.push_back('{1'b1, 16'h0011, 1'b0, 5'd0,  16'h00BB, 1'b1, 5'd4,  1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 5'd0,  16'h0000, 1'b0, 5'd1,  1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd1,  1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 5'd19, 16'h0000, 1'b0, 5'd16, 1'b1});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd16, 1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b1, 5'd7,  16'h0000, 1'b0, 5'd7,  1'b0});
        tbl.push_back('{1'b0, 16'h0000, 1'b0, 5'd0,  16'h0000, 1'b0, 5'd7,  1'b0});
        tbl.push_back('{1'b1, 16'h1234, 1'b1, 5'd1,  16'h1234, 1'b1, 5'd1,  1'b0});
        tbl.push_back('{1'b1, 16'h5678, 1'b0, 5'd0,  16'h5678, 1'b1, 5'd1,  1'b0});
        tbl.push_back('{1'b1, 16'h9ABC, 1'b1, 5'd1,  16'h9ABC, 1'b1, 5'd1,  1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].din, tbl[i].load, tbl[i].dly);
            check($sformatf("vec%0d.out", i),       32'(bus.out),       32'(tbl[i].exp_out));
            check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("vec%0d.delay_cur", i), 32'(bus.delay_cur), 32'(tbl[i].exp_cur));
            check($sformatf("vec%0d.delay_err", i), 32'(bus.delay_err), 32'(tbl[i].exp_err));
        end

        // Steady stream at D=3, then reload to 5 in an enabled cycle.
        step(1'b0, 16'h0, 1'b1, 5'd3);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'(16'h3000 + i), 1'b0, 5'd0);
            check_model("d3stream");
        end
        check("d3stream.valid_before_reload", 32'(bus.out_valid), 32'h1);
        s0 = 16'h5A5A;
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) step(1'b1, s0, 1'b1, 5'd5);
            else        step(1'b1, 16'(16'h6000 + k), 1'b0, 5'd0);
            check($sformatf("reload5.k%0d.out_valid", k), 32'(bus.out_valid), (k == 5) ? 32'h1 : 32'h0);
            check($sformatf("reload5.k%0d.out", k),       32'(bus.out),       (k == 5) ? 32'(s0) : 32'h0);
        end

        // Independent lanes at D=2.
        step(1'b0, 16'h0, 1'b1, 5'd2);
        for (int n = 1; n <= 12; n++) begin
            step(1'b1, {8'(8'hF0 - n), 8'(8'h10 + n)}, 1'b0, 5'd0);
            check($sformatf("lanes.n%0d.lane0", n), 32'(bus.out[7:0]),  (n >= 2) ? 32'(8'(8'h10 + n - 1)) : 32'h0);
            check($sformatf("lanes.n%0d.lane1", n), 32'(bus.out[15:8]), (n >= 2) ? 32'(8'(8'hF0 - n + 1)) : 32'h0);
            check($sformatf("lanes.n%0d.valid", n), 32'(bus.out_valid), (n >= 2) ? 32'h1 : 32'h0);
        end

        // Wrap-around at maximum delay, well past three buffer lengths.
        step(1'b0, 16'h0, 1'b1, 5'(MAX_DELAY));
        for (int i = 0; i < 4 * MAX_DELAY; i++) begin
            step(($urandom_range(0, 7) != 0), 16'($urandom), 1'b0, 5'd0);
            check_model("wrap");
        end

        // Randomized traffic with occasional reloads, including out-of-range values.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 9) < 7), 16'($urandom),
                 ($urandom_range(0, 24) == 0), 5'($urandom_range(0, 20)));
            check_model("rand");
        end

        // Asynchronous reset while valid at D=6.
        step(1'b0, 16'h0, 1'b1, 5'd6);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 16'(16'h7700 + i), 1'b0, 5'd0);
        end
        check_model("d6");
        check("d6.valid_before_rst", 32'(bus.out_valid), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst.out",       32'(bus.out),       32'h0);
        check("arst.out_valid", 32'(bus.out_valid), 32'h0);
        check("arst.delay_cur", 32'(bus.delay_cur), 32'(DEF_D));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        first = 16'hC0DE;
        for (int k = 1; k <= DEF_D; k++) begin
            step(1'b1, (k == 1) ? first : 16'(16'hC000 + k), 1'b0, 5'd0);
            check($sformatf("refill.k%0d.out_valid", k), 32'(bus.out_valid), (k == DEF_D) ? 32'h1 : 32'h0);
            check($sformatf("refill.k%0d.out", k),       32'(bus.out),       (k == DEF_D) ? 32'(first) : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
